core_id_issue: RTL and testbench
================================

Name: core_id_issue

Overview:
- Decode-to-execute issue stage, directly upstream of the execute unit.
- Holds one decoded instruction in a skid register and owns the 32-entry integer register file, written by execute-stage writeback.
- Reads rs1/rs2 with bypassing from execute and writeback, stalls on unresolved execute results, and drops its contents on pipeline flush.
- Counts hazard-stall cycles for performance debug.

Parameters:
XLEN, 32, data and register width
PC_W, 32, program counter width
RFIDX_W, 5, register index width
BJ_W, CORE_BJ_DEC_INST_WIDTH, branch/jump decode bus width
ALU_W, CORE_ALU_INST_WIDTH, ALU op bus width
LSU_W, CORE_LSU_INST_WIDTH, LSU op bus width
CSR_W, CORE_CSR_INST_WIDTH, CSR op bus width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  decoder has an instruction
ready_in  out  1  stage can accept
i_pc, i_branch_predict, i_imm  in  PC_W/1/XLEN  decoded fields
i_rs1_ren, i_rs2_ren, i_rd_wen  in  1 each  operand/dest enables
i_rs1_idx, i_rs2_idx, i_rd_idx  in  RFIDX_W each  register indices
i_bj_bus, i_alu_bus, i_lsu_bus, i_csr_bus  in  BJ_W/ALU_W/LSU_W/CSR_W  op buses
valid_out  out  1  instruction issued to execute
ready_out  in  1  execute ready_in
o_pc, o_branch_predict, o_imm, o_rs1_dat, o_rs2_dat, o_rs1_ren, o_rs2_ren, o_rd_wen, o_rs1_idx, o_rs2_idx, o_rd_idx, o_bj_bus, o_alu_bus, o_lsu_bus, o_csr_bus  out  matching  held fields plus resolved operands
wb_en  in  1  execute writeback strobe
wb_idx  in  RFIDX_W  writeback index
wb_data  in  XLEN  writeback data
ex_fwd_wen  in  1  execute-held instruction writes rd
ex_fwd_idx  in  RFIDX_W  execute rd index
ex_fwd_dat  in  XLEN  execute result
ex_fwd_valid  in  1  ex_fwd_dat is final this cycle; tied to execute writeback strobe
ex_pending  in  1  execute holds an un-retired instruction
flush_req  in  1  commit-stage pipeline flush
stall_cnt  out  16  saturating hazard-stall counter

Behaviour:
- Reset, asynchronous: hold_valid=0, all held fields 0, regfile x1..x31=0, stall_cnt=0. Outputs: valid_out=0, ready_in=1, o_* = 0.
- Hold register:
  - Captures all i_* fields when valid_in & ready_in & ~flush_req.
  - ready_in = ~hold_valid | (valid_out & ready_out) | flush_req.
  - Issue fire (valid_out & ready_out) with no simultaneous capture clears hold_valid.
  - Fire and capture in the same cycle keep hold_valid=1; zero-bubble throughput of one instruction per cycle.
- Flush:
  - flush_req forces valid_out=0 combinationally.
  - hold_valid=0 on the next edge.
  - Any instruction presented that cycle is accepted (ready_in=1) and discarded.
  - Flush has priority over capture and issue.
- Register file:
  - x0 always reads 0; writes to x0 ignored.
  - Write on the rising edge when wb_en=1 and wb_idx!=0.
- Operand resolution, per source, combinational from held idx:
  - idx==0 gives 0.
  - Else, ex_fwd_valid & ex_fwd_wen & ex_fwd_idx==idx gives ex_fwd_dat.
  - Else, wb_en & wb_idx==idx gives wb_data.
  - Else, regfile value.
  - A source with ren=0 still outputs the resolved value, but cannot cause a hazard.
- Hazard:
  - Per source: ren & idx!=0 & ex_pending & ex_fwd_wen & ex_fwd_idx==idx & ~ex_fwd_valid.
  - hazard = OR of rs1/rs2 hazards.
  - valid_out = hold_valid & ~hazard & ~flush_req.
  - o_* remain stable while hold_valid=1 and not fired.
- stall_cnt: +1 on each cycle with hold_valid & hazard & ~flush_req; saturates at 16'hFFFF; never clears except on reset.
- Reset mid-operation drops the held instruction immediately; no partial state survives.
- Latency: one cycle from accept to earliest valid_out.

Test Plan:
- Reset, then write x5=0x1234 via wb_en; issue an instruction reading rs1=x5 -> o_rs1_dat=0x1234, valid_out one cycle after accept; rs2=x0 -> 0.
- Back-to-back stream of 4 instructions with ready_out=1 -> one valid_out per cycle, no bubbles, fields in order.
- Held rs1=x7, ex_pending=1, ex_fwd_idx=7, ex_fwd_wen=1, ex_fwd_valid=0 for 3 cycles, then ex_fwd_valid=1, ex_fwd_dat=0xCAFE -> valid_out low 3 cycles, stall_cnt=3, then issue with o_rs1_dat=0xCAFE.
- Same-cycle wb_en to x9 with 0xBEEF while the held instruction reads x9 -> o_rs2_dat=0xBEEF; the following instruction reading x9 -> 0xBEEF from the regfile.
- ready_out=0 with hold full and a new valid_in -> ready_in=0, o_* stable; assert flush_req -> valid_out=0 same cycle, hold empty next cycle, ready_in=1, the flush-cycle input is discarded.
- wb_en to x0 with 0xFFFF_FFFF, then read x0 -> 0.

Source files
------------

// File: rtl/core_id_issue_if.sv
// ---------------------------------------------------------------------------
// core_id_issue_if
// Decode -> issue -> execute pipe bundle for the issue stage.
//   Upstream (decoder side):  valid_in / ready_in handshake plus decoded i_* fields.
//   Downstream (execute side): valid_out / ready_out handshake plus held o_* fields
//                              and the resolved rs1/rs2 operands.
// Modports:
//   slave  - the issue stage (consumes i_*, ready_out; produces ready_in, valid_out, o_*)
//   master - the environment around it (decoder + execute)
// ---------------------------------------------------------------------------
interface core_id_issue_if #(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter int RFIDX_W = 5,
    parameter int BJ_W    = 17,
    parameter int ALU_W   = 21,
    parameter int LSU_W   = 13,
    parameter int CSR_W   = 26
);
    // decoder side
    logic               valid_in;
    logic               ready_in;
    logic [PC_W-1:0]    i_pc;
    logic               i_branch_predict;
    logic [XLEN-1:0]    i_imm;
    logic               i_rs1_ren;
    logic               i_rs2_ren;
    logic               i_rd_wen;
    logic [RFIDX_W-1:0] i_rs1_idx;
    logic [RFIDX_W-1:0] i_rs2_idx;
    logic [RFIDX_W-1:0] i_rd_idx;
    logic [BJ_W-1:0]    i_bj_bus;
    logic [ALU_W-1:0]   i_alu_bus;
    logic [LSU_W-1:0]   i_lsu_bus;
    logic [CSR_W-1:0]   i_csr_bus;

    // execute side
    logic               valid_out;
    logic               ready_out;
    logic [PC_W-1:0]    o_pc;
    logic               o_branch_predict;
    logic [XLEN-1:0]    o_imm;
    logic [XLEN-1:0]    o_rs1_dat;
    logic [XLEN-1:0]    o_rs2_dat;
    logic               o_rs1_ren;
    logic               o_rs2_ren;
    logic               o_rd_wen;
    logic [RFIDX_W-1:0] o_rs1_idx;
    logic [RFIDX_W-1:0] o_rs2_idx;
    logic [RFIDX_W-1:0] o_rd_idx;
    logic [BJ_W-1:0]    o_bj_bus;
    logic [ALU_W-1:0]   o_alu_bus;
    logic [LSU_W-1:0]   o_lsu_bus;
    logic [CSR_W-1:0]   o_csr_bus;

    modport slave (
        input  valid_in, i_pc, i_branch_predict, i_imm, i_rs1_ren, i_rs2_ren, i_rd_wen,
               i_rs1_idx, i_rs2_idx, i_rd_idx, i_bj_bus, i_alu_bus, i_lsu_bus, i_csr_bus,
               ready_out,
        output ready_in, valid_out, o_pc, o_branch_predict, o_imm, o_rs1_dat, o_rs2_dat,
               o_rs1_ren, o_rs2_ren, o_rd_wen, o_rs1_idx, o_rs2_idx, o_rd_idx,
               o_bj_bus, o_alu_bus, o_lsu_bus, o_csr_bus
    );

    modport master (
        output valid_in, i_pc, i_branch_predict, i_imm, i_rs1_ren, i_rs2_ren, i_rd_wen,
               i_rs1_idx, i_rs2_idx, i_rd_idx, i_bj_bus, i_alu_bus, i_lsu_bus, i_csr_bus,
               ready_out,
        input  ready_in, valid_out, o_pc, o_branch_predict, o_imm, o_rs1_dat, o_rs2_dat,
               o_rs1_ren, o_rs2_ren, o_rd_wen, o_rs1_idx, o_rs2_idx, o_rd_idx,
               o_bj_bus, o_alu_bus, o_lsu_bus, o_csr_bus
    );
endinterface

// File: rtl/core_id_issue.sv
// ---------------------------------------------------------------------------
// core_id_issue
// Decode-to-execute issue stage. Holds one decoded instruction in a skid
// register, owns the 32-entry integer register file (written by writeback),
// resolves rs1/rs2 with bypass from execute and writeback, stalls on execute
// results that are not yet final, drops its contents on flush, and counts
// hazard-stall cycles.
// Ports:
//   clk, rst_n         - rising-edge clock, asynchronous active-low reset
//   bus (slave)        - decoder/execute handshake and instruction fields
//   wb_en/idx/data     - register file write port (execute writeback)
//   ex_fwd_*           - execute-stage forwarding source
//   ex_pending         - execute holds an un-retired instruction
//   flush_req          - commit-stage pipeline flush
//   stall_cnt          - saturating hazard-stall cycle counter
// ---------------------------------------------------------------------------
module core_id_issue #(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter int RFIDX_W = 5,
    parameter int BJ_W    = 17,
    parameter int ALU_W   = 21,
    parameter int LSU_W   = 13,
    parameter int CSR_W   = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    core_id_issue_if.slave     bus,
    input  logic               wb_en,
    input  logic [RFIDX_W-1:0] wb_idx,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               ex_fwd_wen,
    input  logic [RFIDX_W-1:0] ex_fwd_idx,
    input  logic [XLEN-1:0]    ex_fwd_dat,
    input  logic               ex_fwd_valid,
    input  logic               ex_pending,
    input  logic               flush_req,
    output logic [15:0]        stall_cnt
);

    localparam int HOLD_W = PC_W + 1 + XLEN + 3 + 3 * RFIDX_W + BJ_W + ALU_W + LSU_W + CSR_W;
    localparam int NREG   = 32;

    logic                 hold_valid_q, hold_valid_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [HOLD_W-1:0]    i_pack_s;
    logic [XLEN-1:0]      rf_q [NREG];
    logic [XLEN-1:0]      rf_d [NREG];
    logic [15:0]          stall_cnt_q, stall_cnt_d;

    // unpacked view of the held instruction
    logic [PC_W-1:0]      h_pc_s;
    logic                 h_bp_s;
    logic [XLEN-1:0]      h_imm_s;
    logic                 h_rs1_ren_s, h_rs2_ren_s, h_rd_wen_s;
    logic [RFIDX_W-1:0]   h_rs1_idx_s, h_rs2_idx_s, h_rd_idx_s;
    logic [BJ_W-1:0]      h_bj_s;
    logic [ALU_W-1:0]     h_alu_s;
    logic [LSU_W-1:0]     h_lsu_s;
    logic [CSR_W-1:0]     h_csr_s;

    logic [XLEN-1:0]      rs1_dat_s, rs2_dat_s;
    logic                 hazard_s, valid_out_s, fire_s, ready_in_s, capture_s;

    // Execute result wins over writeback (it is the younger producer), then the regfile.
    function automatic logic [XLEN-1:0] resolve_src(
        input logic [RFIDX_W-1:0] idx,
        input logic [XLEN-1:0]    rf_val,
        input logic               fwd_ok,
        input logic [RFIDX_W-1:0] fwd_idx,
        input logic [XLEN-1:0]    fwd_dat,
        input logic               wb_ok,
        input logic [RFIDX_W-1:0] w_idx,
        input logic [XLEN-1:0]    w_dat
    );
        logic [XLEN-1:0] r;
        if (idx == {RFIDX_W{1'b0}}) begin
            r = {XLEN{1'b0}};
        end else if (fwd_ok && (fwd_idx == idx)) begin
            r = fwd_dat;
        end else if (wb_ok && (w_idx == idx)) begin
            r = w_dat;
        end else begin
            r = rf_val;
        end
        return r;
    endfunction

    // A source stalls only if it is read, non-x0, and execute will produce it later.
    function automatic logic src_hazard(
        input logic               ren,
        input logic [RFIDX_W-1:0] idx,
        input logic               pend,
        input logic               fwd_wen,
        input logic [RFIDX_W-1:0] fwd_idx,
        input logic               fwd_valid
    );
        return ren && (idx != {RFIDX_W{1'b0}}) && pend && fwd_wen &&
               (fwd_idx == idx) && !fwd_valid;
    endfunction

    assign i_pack_s = {bus.i_pc, bus.i_branch_predict, bus.i_imm,
                       bus.i_rs1_ren, bus.i_rs2_ren, bus.i_rd_wen,
                       bus.i_rs1_idx, bus.i_rs2_idx, bus.i_rd_idx,
                       bus.i_bj_bus, bus.i_alu_bus, bus.i_lsu_bus, bus.i_csr_bus};

    assign {h_pc_s, h_bp_s, h_imm_s, h_rs1_ren_s, h_rs2_ren_s, h_rd_wen_s,
            h_rs1_idx_s, h_rs2_idx_s, h_rd_idx_s,
            h_bj_s, h_alu_s, h_lsu_s, h_csr_s} = hold_q;

    // Operand resolution, hazard detection and the issue/accept handshake.
    always_comb begin
        rs1_dat_s = resolve_src(h_rs1_idx_s, rf_q[h_rs1_idx_s], ex_fwd_valid && ex_fwd_wen,
                                ex_fwd_idx, ex_fwd_dat, wb_en, wb_idx, wb_data);
        rs2_dat_s = resolve_src(h_rs2_idx_s, rf_q[h_rs2_idx_s], ex_fwd_valid && ex_fwd_wen,
                                ex_fwd_idx, ex_fwd_dat, wb_en, wb_idx, wb_data);
        hazard_s  = src_hazard(h_rs1_ren_s, h_rs1_idx_s, ex_pending, ex_fwd_wen,
                               ex_fwd_idx, ex_fwd_valid) ||
                    src_hazard(h_rs2_ren_s, h_rs2_idx_s, ex_pending, ex_fwd_wen,
                               ex_fwd_idx, ex_fwd_valid);
        valid_out_s = hold_valid_q && !hazard_s && !flush_req;
        fire_s      = valid_out_s && bus.ready_out;
        // Flush accepts (and discards) whatever the decoder presents.
        ready_in_s  = !hold_valid_q || fire_s || flush_req;
        capture_s   = bus.valid_in && ready_in_s && !flush_req;
    end

    // Next-state for the hold register, register file and stall counter.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush_req) begin
            hold_valid_d = 1'b0;
        end else if (capture_s) begin
            hold_valid_d = 1'b1;
        end else if (fire_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        if (capture_s) begin
            hold_d = i_pack_s;
        end else begin
            hold_d = hold_q;
        end

        if (hold_valid_q && hazard_s && !flush_req && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        // Entry 0 is never written, so x0 stays zero.
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = (wb_en && (i != 0) && (wb_idx == RFIDX_W'(i))) ? wb_data : rf_q[i];
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_q       <= {HOLD_W{1'b0}};
            stall_cnt_q  <= 16'd0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            stall_cnt_q  <= stall_cnt_d;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign bus.ready_in         = ready_in_s;
    assign bus.valid_out        = valid_out_s;
    assign bus.o_pc             = h_pc_s;
    assign bus.o_branch_predict = h_bp_s;
    assign bus.o_imm            = h_imm_s;
    assign bus.o_rs1_dat        = rs1_dat_s;
    assign bus.o_rs2_dat        = rs2_dat_s;
    assign bus.o_rs1_ren        = h_rs1_ren_s;
    assign bus.o_rs2_ren        = h_rs2_ren_s;
    assign bus.o_rd_wen         = h_rd_wen_s;
    assign bus.o_rs1_idx        = h_rs1_idx_s;
    assign bus.o_rs2_idx        = h_rs2_idx_s;
    assign bus.o_rd_idx         = h_rd_idx_s;
    assign bus.o_bj_bus         = h_bj_s;
    assign bus.o_alu_bus        = h_alu_s;
    assign bus.o_lsu_bus        = h_lsu_s;
    assign bus.o_csr_bus        = h_csr_s;
    assign stall_cnt            = stall_cnt_q;

endmodule

// File: tb/tb_core_id_issue.sv
// ---------------------------------------------------------------------------
// tb_core_id_issue
// Directed scenarios for the issue stage followed by a randomized run checked
// against a queue-based model of accepted-but-not-yet-issued instructions.
// ---------------------------------------------------------------------------
module tb_core_id_issue;

    localparam int XLEN = 32, PC_W = 32, RFIDX_W = 5;
    localparam int BJ_W = 17, ALU_W = 21, LSU_W = 13, CSR_W = 26;

    typedef struct {
        logic [31:0] pc;
        logic        bp;
        logic [31:0] imm;
        logic        r1, r2, rdw;
        logic [4:0]  i1, i2, rd;
        logic [16:0] bj;
        logic [20:0] alu;
        logic [12:0] lsu;
        logic [25:0] csr;
    } instr_t;

    logic        clk, rst_n;
    logic        wb_en, ex_fwd_wen, ex_fwd_valid, ex_pending, flush_req;
    logic [4:0]  wb_idx, ex_fwd_idx;
    logic [31:0] wb_data, ex_fwd_dat;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;
    int exp_stall = 0;

    core_id_issue_if #(.XLEN(XLEN), .PC_W(PC_W), .RFIDX_W(RFIDX_W), .BJ_W(BJ_W),
                       .ALU_W(ALU_W), .LSU_W(LSU_W), .CSR_W(CSR_W)) bus ();

    core_id_issue #(.XLEN(XLEN), .PC_W(PC_W), .RFIDX_W(RFIDX_W), .BJ_W(BJ_W),
                    .ALU_W(ALU_W), .LSU_W(LSU_W), .CSR_W(CSR_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .ex_fwd_wen(ex_fwd_wen), .ex_fwd_idx(ex_fwd_idx), .ex_fwd_dat(ex_fwd_dat),
        .ex_fwd_valid(ex_fwd_valid), .ex_pending(ex_pending),
        .flush_req(flush_req), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state for the randomized run
    logic [31:0] rf_m [32];
    instr_t      exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk_instr(input logic [31:0] pc, input logic r1, input logic [4:0] i1,
                                        input logic r2, input logic [4:0] i2);
        instr_t x;
        x.pc = pc; x.bp = 1'($urandom); x.imm = $urandom; x.r1 = r1; x.r2 = r2;
        x.rdw = 1'($urandom); x.i1 = i1; x.i2 = i2; x.rd = 5'($urandom);
        x.bj = 17'($urandom); x.alu = 21'($urandom); x.lsu = 13'($urandom); x.csr = 26'($urandom);
        return x;
    endfunction

    task automatic present(input instr_t x);
        bus.valid_in = 1'b1; bus.i_pc = x.pc; bus.i_branch_predict = x.bp; bus.i_imm = x.imm;
        bus.i_rs1_ren = x.r1; bus.i_rs2_ren = x.r2; bus.i_rd_wen = x.rdw;
        bus.i_rs1_idx = x.i1; bus.i_rs2_idx = x.i2; bus.i_rd_idx = x.rd;
        bus.i_bj_bus = x.bj; bus.i_alu_bus = x.alu; bus.i_lsu_bus = x.lsu; bus.i_csr_bus = x.csr;
    endtask

    task automatic quiet();
        bus.valid_in = 1'b0; bus.ready_out = 1'b0;
        wb_en = 1'b0; wb_idx = 5'd0; wb_data = 32'd0;
        ex_fwd_wen = 1'b0; ex_fwd_idx = 5'd0; ex_fwd_dat = 32'd0; ex_fwd_valid = 1'b0;
        ex_pending = 1'b0; flush_req = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        present(mk_instr(32'd0, 1'b0, 5'd0, 1'b0, 5'd0));
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        exp_q.delete();
        exp_stall = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out got=%0b exp=0", bus.valid_out); end
        checks++; if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL reset_ready_in got=%0b exp=1", bus.ready_in); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (bus.o_pc !== 32'd0 || bus.o_imm !== 32'd0 || bus.o_alu_bus !== 21'd0) begin
            failures++; $display("FAIL reset_o_fields pc=%h imm=%h alu=%h exp=0", bus.o_pc, bus.o_imm, bus.o_alu_bus); end
        tick();
    endtask

    task automatic test_basic();
        instr_t a;
        wb_en = 1'b1; wb_idx = 5'd5; wb_data = 32'h1234;
        tick();
        wb_en = 1'b0;
        a = mk_instr(32'h100, 1'b1, 5'd5, 1'b1, 5'd0);
        present(a); bus.ready_out = 1'b1;
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL basic_pre_accept_valid got=%0b exp=0", bus.valid_out); end
        tick();
        bus.valid_in = 1'b0;
        #1;
        checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL basic_valid_out got=%0b exp=1", bus.valid_out); end
        checks++; if (bus.o_rs1_dat !== 32'h1234) begin failures++; $display("FAIL basic_rs1 got=%h exp=00001234", bus.o_rs1_dat); end
        checks++; if (bus.o_rs2_dat !== 32'h0) begin failures++; $display("FAIL basic_rs2_x0 got=%h exp=0", bus.o_rs2_dat); end
        checks++; if (bus.o_pc !== a.pc || bus.o_imm !== a.imm || bus.o_csr_bus !== a.csr) begin
            failures++; $display("FAIL basic_fields pc=%h imm=%h exp pc=%h imm=%h", bus.o_pc, bus.o_imm, a.pc, a.imm); end
        tick();
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL basic_post_fire_valid got=%0b exp=0", bus.valid_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        instr_t s [4];
        for (int k = 0; k < 4; k++) s[k] = mk_instr(32'h200 + 32'(k * 4), 1'b0, 5'd0, 1'b0, 5'd0);
        bus.ready_out = 1'b1;
        present(s[0]);
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) present(s[k]); else bus.valid_in = 1'b0;
            #1;
            checks++; if (bus.valid_out !== 1'b1 || bus.o_pc !== s[k-1].pc || bus.o_bj_bus !== s[k-1].bj) begin
                failures++; $display("FAIL b2b_issue_%0d valid=%0b pc=%h exp valid=1 pc=%h", k-1, bus.valid_out, bus.o_pc, s[k-1].pc); end
            checks++; if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%0b exp=1", k-1, bus.ready_in); end
            tick();
        end
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", bus.valid_out); end
        tick();
    endtask

    task automatic test_hazard();
        instr_t a;
        a = mk_instr(32'h300, 1'b1, 5'd7, 1'b0, 5'd0);
        present(a); bus.ready_out = 1'b1;
        ex_pending = 1'b1; ex_fwd_wen = 1'b1; ex_fwd_idx = 5'd7; ex_fwd_valid = 1'b0; ex_fwd_dat = 32'h5555;
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL hazard_stall_%0d valid=%0b exp=0", i, bus.valid_out); end
            tick();
        end
        exp_stall += 3;
        ex_fwd_valid = 1'b1; ex_fwd_dat = 32'hCAFE;
        #1;
        checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL hazard_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
        checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL hazard_release got=%0b exp=1", bus.valid_out); end
        checks++; if (bus.o_rs1_dat !== 32'hCAFE) begin failures++; $display("FAIL hazard_fwd_dat got=%h exp=0000cafe", bus.o_rs1_dat); end
        tick();
        quiet();
        tick();
    endtask

    task automatic test_wb_bypass();
        instr_t b, c;
        b = mk_instr(32'h400, 1'b0, 5'd0, 1'b1, 5'd9);
        c = mk_instr(32'h404, 1'b1, 5'd9, 1'b0, 5'd0);
        present(b); bus.ready_out = 1'b1;
        tick();
        wb_en = 1'b1; wb_idx = 5'd9; wb_data = 32'hBEEF;
        present(c);
        #1;
        checks++; if (bus.valid_out !== 1'b1 || bus.o_rs2_dat !== 32'hBEEF) begin
            failures++; $display("FAIL wb_bypass valid=%0b rs2=%h exp valid=1 rs2=0000beef", bus.valid_out, bus.o_rs2_dat); end
        tick();
        wb_en = 1'b0; bus.valid_in = 1'b0;
        #1;
        checks++; if (bus.valid_out !== 1'b1 || bus.o_pc !== c.pc || bus.o_rs1_dat !== 32'hBEEF) begin
            failures++; $display("FAIL wb_regfile valid=%0b pc=%h rs1=%h exp pc=%h rs1=0000beef", bus.valid_out, bus.o_pc, bus.o_rs1_dat, c.pc); end
        tick();
        bus.ready_out = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        instr_t a, b;
        a = mk_instr(32'h500, 1'b0, 5'd0, 1'b0, 5'd0);
        b = mk_instr(32'h504, 1'b0, 5'd0, 1'b0, 5'd0);
        bus.ready_out = 1'b0;
        present(a);
        tick();
        present(b);
        #1;
        checks++; if (bus.ready_in !== 1'b0) begin failures++; $display("FAIL flush_full_ready got=%0b exp=0", bus.ready_in); end
        tick();
        #1;
        checks++; if (bus.valid_out !== 1'b1 || bus.o_pc !== a.pc || bus.o_imm !== a.imm) begin
            failures++; $display("FAIL flush_hold_stable valid=%0b pc=%h exp valid=1 pc=%h", bus.valid_out, bus.o_pc, a.pc); end
        flush_req = 1'b1;
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL flush_same_cycle_valid got=%0b exp=0", bus.valid_out); end
        checks++; if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL flush_same_cycle_ready got=%0b exp=1", bus.ready_in); end
        tick();
        flush_req = 1'b0; bus.valid_in = 1'b0;
        #1;
        checks++; if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1) begin
            failures++; $display("FAIL flush_empty valid=%0b ready=%0b exp valid=0 ready=1", bus.valid_out, bus.ready_in); end
        tick();
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL flush_discard got=%0b exp=0", bus.valid_out); end
        tick();
    endtask

    task automatic test_x0();
        instr_t a;
        wb_en = 1'b1; wb_idx = 5'd0; wb_data = 32'hFFFF_FFFF;
        a = mk_instr(32'h600, 1'b1, 5'd0, 1'b1, 5'd0);
        present(a); bus.ready_out = 1'b0;
        tick();
        wb_en = 1'b0; bus.valid_in = 1'b0;
        #1;
        checks++; if (bus.o_rs1_dat !== 32'd0 || bus.o_rs2_dat !== 32'd0) begin
            failures++; $display("FAIL x0_read rs1=%h rs2=%h exp=0", bus.o_rs1_dat, bus.o_rs2_dat); end
        checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL x0_valid got=%0b exp=1", bus.valid_out); end
        bus.ready_out = 1'b1;
        tick();
        quiet();
    endtask

    function automatic logic [31:0] m_src(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (ex_fwd_valid && ex_fwd_wen && ex_fwd_idx == idx) return ex_fwd_dat;
        if (wb_en && wb_idx == idx) return wb_data;
        return rf_m[idx];
    endfunction

    function automatic logic m_haz(input logic ren, input logic [4:0] idx);
        return ren && idx != 5'd0 && ex_pending && ex_fwd_wen && ex_fwd_idx == idx && !ex_fwd_valid;
    endfunction

    task automatic test_random();
        instr_t cur, h;
        logic haz, e_valid, e_fire, e_ready;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            cur = mk_instr($urandom, 1'($urandom), 5'($urandom_range(0, 7)),
                           1'($urandom), 5'($urandom_range(0, 7)));
            present(cur);
            bus.valid_in  = ($urandom_range(0, 3) != 0);
            bus.ready_out = ($urandom_range(0, 3) != 0);
            flush_req     = ($urandom_range(0, 15) == 0);
            wb_en         = 1'($urandom);
            wb_idx        = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            ex_pending    = 1'($urandom);
            ex_fwd_wen    = 1'($urandom);
            ex_fwd_idx    = 5'($urandom_range(0, 7));
            ex_fwd_valid  = ($urandom_range(0, 2) == 0);
            ex_fwd_dat    = $urandom;
            #1;
            haz = 1'b0;
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                haz = m_haz(h.r1, h.i1) || m_haz(h.r2, h.i2);
            end
            e_valid = (exp_q.size() > 0) && !haz && !flush_req;
            e_fire  = e_valid && bus.ready_out;
            e_ready = (exp_q.size() == 0) || e_fire || flush_req;
            checks++; if (bus.valid_out !== e_valid) begin failures++; $display("FAIL rand_valid_out c=%0d got=%0b exp=%0b", c, bus.valid_out, e_valid); end
            checks++; if (bus.ready_in !== e_ready) begin failures++; $display("FAIL rand_ready_in c=%0d got=%0b exp=%0b", c, bus.ready_in, e_ready); end
            checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL rand_stall_cnt c=%0d got=%0d exp=%0d", c, stall_cnt, exp_stall); end
            if (exp_q.size() > 0) begin
                checks++; if (bus.o_pc !== h.pc || bus.o_rd_idx !== h.rd || bus.o_lsu_bus !== h.lsu) begin
                    failures++; $display("FAIL rand_fields c=%0d pc=%h exp=%h", c, bus.o_pc, h.pc); end
                checks++; if (bus.o_rs1_dat !== m_src(h.i1)) begin
                    failures++; $display("FAIL rand_rs1 c=%0d got=%h exp=%h", c, bus.o_rs1_dat, m_src(h.i1)); end
                checks++; if (bus.o_rs2_dat !== m_src(h.i2)) begin
                    failures++; $display("FAIL rand_rs2 c=%0d got=%h exp=%h", c, bus.o_rs2_dat, m_src(h.i2)); end
            end
            if (exp_q.size() > 0 && haz && !flush_req && exp_stall < 65535) exp_stall++;
            if (flush_req) begin
                exp_q.delete();
            end else begin
                if (e_fire) void'(exp_q.pop_front());
                if (bus.valid_in && e_ready) exp_q.push_back(cur);
            end
            if (wb_en && wb_idx != 5'd0) rf_m[wb_idx] = wb_data;
            tick();
        end
        quiet();
    endtask

    task automatic test_reset_mid();
        bus.ready_out = 1'b0;
        ex_pending = 1'b1; ex_fwd_wen = 1'b1; ex_fwd_idx = 5'd3; ex_fwd_valid = 1'b0;
        present(mk_instr(32'h700, 1'b1, 5'd3, 1'b0, 5'd0));
        tick();
        bus.valid_in = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1) begin
            failures++; $display("FAIL reset_mid_handshake valid=%0b ready=%0b exp valid=0 ready=1", bus.valid_out, bus.ready_in); end
        checks++; if (stall_cnt !== 16'd0 || bus.o_pc !== 32'd0) begin
            failures++; $display("FAIL reset_mid_state stall=%0d pc=%h exp=0", stall_cnt, bus.o_pc); end
        tick();
        rst_n = 1'b1;
        quiet();
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        quiet();
        test_reset();
        test_basic();
        test_back_to_back();
        test_hazard();
        test_wb_bypass();
        test_flush();
        test_x0();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
